// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle control stage in front of an external 8-bit add/sub ALU. It
// accepts one instruction at a time over a valid/ready handshake, reads two
// operands from a 4 x 8-bit register file, presents them to the ALU, captures
// the ALU result and writes it back to the destination register.
//
// Instruction format: [7:6] opcode (00 ADD, 01 SUB, 10 LI, 11 NOP),
//                     [5:4] rd, [3:2] rs, [3:0] imm (LI only).
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   instr_valid  instr is valid this cycle
//   instr        instruction word
//   instr_ready  block can accept an instruction (IDLE and not in reset)
//   alu_rd_data  registered operand A to the ALU
//   alu_rs_data  registered operand B to the ALU
//   alu_select   0 = add, 1 = subtract (rd - rs)
//   alu_out      combinational result returned by the ALU
//   result       value being retired (valid while done)
//   done         one-cycle pulse per retired instruction
//   dbg_addr     debug register read address
//   dbg_data     combinational read of regfile[dbg_addr]
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int NREG = 4,
    parameter int W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    input  logic [7:0]              instr,
    output logic                    instr_ready,
    output logic [W-1:0]            alu_rd_data,
    output logic [W-1:0]            alu_rs_data,
    output logic                    alu_select,
    input  logic [W-1:0]            alu_out,
    output logic [W-1:0]            result,
    output logic                    done,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [W-1:0]            dbg_data
);

    localparam int AW = $clog2(NREG);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LI  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        OPER,
        CAPT,
        WB
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [1:0]    op_reg;
    logic [AW-1:0] rd_reg;
    logic [W-1:0]  alu_rd_data_reg;
    logic [W-1:0]  alu_rs_data_reg;
    logic          alu_select_reg;
    logic [W-1:0]  result_reg;
    logic [W-1:0]  regfile [NREG];
    logic          wr_en;

    wire [1:0]    in_op = instr[7:6];
    wire [AW-1:0] in_rd = instr[5:4];
    wire [AW-1:0] in_rs = instr[3:2];
    wire          accept = (state_reg == IDLE) && instr_valid;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (instr_valid) begin
                    // ADD/SUB need the ALU round trip; LI/NOP retire directly
                    state_next = (in_op == OP_ADD || in_op == OP_SUB) ? OPER : WB;
                end
            end
            OPER:    state_next = CAPT;
            CAPT:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------- datapath regs
    // Operands, select and result only change in their update states and
    // hold their last value otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_reg          <= OP_NOP;
            rd_reg          <= '0;
            alu_rd_data_reg <= '0;
            alu_rs_data_reg <= '0;
            alu_select_reg  <= 1'b0;
            result_reg      <= '0;
        end else begin
            if (accept) begin
                op_reg <= in_op;
                rd_reg <= in_rd;
                case (in_op)
                    OP_ADD, OP_SUB: begin
                        // Both reads see pre-instruction values, so rd == rs works
                        alu_rd_data_reg <= regfile[in_rd];
                        alu_rs_data_reg <= regfile[in_rs];
                        alu_select_reg  <= in_op[0];
                    end
                    OP_LI:   result_reg <= {{(W-4){1'b0}}, instr[3:0]};
                    default: result_reg <= '0;
                endcase
            end
            if (state_reg == CAPT) begin
                result_reg <= alu_out;
            end
        end
    end

    // ------------------------------------------------------- register file
    // Write happens on the edge leaving WB, so dbg_data still shows the old
    // rd value during WB.
    assign wr_en = (state_reg == WB) && (op_reg != OP_NOP);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : gen_reg
            logic [W-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (wr_en && (rd_reg == AW'(gi))) begin
                    data_reg <= result_reg;
                end
            end

            assign regfile[gi] = data_reg;
        end
    endgenerate

    // ------------------------------------------------------------- outputs
    assign instr_ready = (state_reg == IDLE) && rst_n;
    assign alu_rd_data = alu_rd_data_reg;
    assign alu_rs_data = alu_rs_data_reg;
    assign alu_select  = alu_select_reg;
    assign result      = result_reg;
    assign done        = (state_reg == WB);
    assign dbg_data    = regfile[dbg_addr];

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control stage sitting directly upstream of the 8-bit `ALU`. It accepts one 8-bit instruction at a time over a valid/ready handshake and reads two operands from an internal 4 x 8-bit register file. It drives those operands and the add/sub select onto the ALU's `rd_data`/`rs_data`/`select` inputs, captures the ALU's `out`, and writes the result back to the destination register.

## Interface
- `NREG`, 4, number of registers in the file (fixed; 2-bit addresses)
- `W`, 8, datapath width (fixed; matches ALU)
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `instr_valid` input 1: `instr` is valid this cycle.
- `instr` input 8: `[7:6]` opcode, `[5:4]` rd, `[3:2]` rs, `[3:0]` imm (LI only).
- `instr_ready` output 1: block can accept an instruction.
- `alu_rd_data` output 8: registered operand A to ALU `rd_data`.
- `alu_rs_data` output 8: registered operand B to ALU `rs_data`.
- `alu_select` output 1: to ALU `select`; 0 = add, 1 = subtract (rd - rs).
- `alu_out` input 8: combinational result from ALU `out`.
- `result` output 8: value being retired (valid while `done`).
- `done` output 1: one-cycle pulse per retired instruction.
- `dbg_addr` input 2: debug read address.
- `dbg_data` output 8: combinational read of `regfile[dbg_addr]`.

## Operation
- Opcodes:
  - 00 ADD: rd <= rd + rs.
  - 01 SUB: rd <= rd - rs.
  - 10 LI: rd <= {4'b0, imm}.
  - 11 NOP: no write, still retires.
- Arithmetic is modulo 2^8; carry and borrow are discarded; no flags.
- All four registers are general purpose and writable; r0 is not hardwired.
- FSM states: IDLE, OPER, CAPT, WB.
  - IDLE: `instr_ready`=1. On `instr_valid`: ADD/SUB go to OPER; LI/NOP go to WB. Otherwise stay in IDLE.
  - OPER: `alu_rd_data`=regfile[rd], `alu_rs_data`=regfile[rs] and `alu_select`=opcode[0] are all registered on entry and stable. Always goes to CAPT.
  - CAPT: `result_q` <= `alu_out`. Always goes to WB.
  - WB: `done`=1, `result`=`result_q` (LI: zero-extended imm; NOP: 0x00). At the edge leaving WB, regfile[rd] <= `result` unless the opcode is NOP. Always goes to IDLE.
- rd == rs is legal; both operands read the pre-instruction value (ADD r1,r1 doubles r1).
- Operand, select and result registers hold their last value outside their update states.
- `instr` is sampled only on the accepting edge; it is ignored while `instr_ready`=0.
- `dbg_data` shows the current contents; during WB it still shows the old rd value.

## Timing
- While `rst_n`=0 at an edge, all of the following clear and hold:
  - state = IDLE;
  - all registers = 0x00;
  - `alu_rd_data`, `alu_rs_data`, `result` = 0x00;
  - `alu_select`, `done` = 0.
- `instr_ready` = (state==IDLE) && `rst_n`, so it is 0 during reset.
- Reset asserted mid-instruction aborts it: no writeback, no `done`.
- ADD/SUB, accepted at edge E0:
  - after E0: OPER;
  - after E1: CAPT;
  - after E2: WB (`done`=1);
  - at E3: register written;
  - after E3: IDLE.
  - Throughput is 1 per 4 cycles.
- LI/NOP, accepted at edge E0:
  - after E0: WB (`done`=1);
  - at E1: write;
  - after E1: IDLE.
  - Throughput is 1 per 2 cycles.
- The ALU sees stable operands for the entire OPER cycle; `alu_out` is sampled only at the CAPT->WB edge.
- A held `instr_valid` with a changing `instr` while not ready has no effect. An instruction waiting on `instr_valid` is accepted on the first IDLE edge.
- A write to rd at E3 is visible to the next instruction's operand read.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `instr_valid`=1 -> `instr_ready`=0, `done`=0, all ALU ports 0x00, `dbg_data`=0x00 for r0..r3.
- LI r1,3; LI r2,2; SUB r1,r2 -> during OPER `alu_rd_data`=0x03, `alu_rs_data`=0x02, `alu_select`=1; `done` with `result`=0x01 exactly 3 cycles after accept; then r1=0x01.
- LI r0,15; ADD r0,r0; ADD r0,r0 -> results 0x1E then 0x3C; r0=0x3C.
- Wrap and borrow:
  - r3=0x00, r1=0x01, SUB r3,r1 -> result 0xFF;
  - then ADD r3,r1 -> result 0x00.
- Handshake: keep `instr_valid`=1 with back-to-back ADD, LI, NOP -> accepts spaced 4 then 2 cycles apart; exactly three `done` pulses; NOP leaves all registers unchanged.
- Reset mid-op: assert `rst_n`=0 while in CAPT of ADD r2,r2 (r2=0x05) -> no `done`; r2=0x00 after reset; next instruction accepted normally.
